// File: rtl/irq_ctrl_if.sv
// Register port bundle for irq_ctrl.
// master drives we/addr/wd, slave returns combinational rd.
interface irq_ctrl_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (
    output we, addr, wd,
    input  rd
  );

  modport slave (
    input  we, addr, wd,
    output rd
  );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-detecting fixed-priority interrupt controller with IACK/EOI flow.
// Ports: clk, rst_n, irq, iack, bus (reg port), int_req/vec/id, in_service.
module irq_ctrl #(
  parameter int          N_IRQ     = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0180,
  parameter int          VEC_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic             iack,
  irq_ctrl_if.slave        bus,
  output logic             int_req,
  output logic [31:0]      int_vec,
  output logic [2:0]       int_id,
  output logic             in_service
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [N_IRQ-1:0] enable;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;
  logic [2:0]       win;
  logic             en_we;
  logic             eoi;
  logic             ack;
  logic             unused_wd;

  assign unused_wd = ^bus.wd[31:N_IRQ];

  assign rise  = irq & ~irq_prev;
  assign cand  = pending & enable;
  assign en_we = bus.we && (bus.addr == 2'd0);
  assign eoi   = bus.we && (bus.addr == 2'd3);
  assign ack   = (state == REQ) && iack;
  assign w1c   = (bus.we && (bus.addr == 2'd1))
               ? bus.wd[N_IRQ-1:0] : '0;

  // lowest set index wins
  always_comb begin
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (cand[i]) win = 3'(i);
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_IRQ; i++)
      ack_clr[i] = ack && (int_id == 3'(i));
  end

  // rise is OR-ed last so a new event beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev <= '0;
      enable   <= '0;
      pending  <= '0;
      int_id   <= '0;
    end else begin
      irq_prev <= irq;
      if (en_we) enable <= bus.wd[N_IRQ-1:0];
      pending <= (pending & ~w1c & ~ack_clr) | rise;
      if (state == IDLE && cand != '0) int_id <= win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cand != '0) state_nx = REQ;
      REQ:     if (iack)       state_nx = SVC;
      SVC:     if (eoi)        state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    int_req    = 1'b0;
    in_service = 1'b0;
    unique case (state)
      REQ:     int_req    = 1'b1;
      SVC:     in_service = 1'b1;
      default: ;
    endcase
  end

  assign int_vec = VEC_BASE + (32'(int_id) << VEC_SHIFT);

  always_comb begin
    bus.rd = '0;
    unique case (bus.addr)
      2'd0: bus.rd = 32'(enable);
      2'd1: bus.rd = 32'(pending);
      2'd2: bus.rd = {27'b0, in_service, int_req, int_id};
      2'd3: bus.rd = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: spec-level model checked every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq;
  logic       iack;
  logic       int_req;
  logic [31:0] int_vec;
  logic [2:0] int_id;
  logic       in_service;

  int total = 0;
  int bad   = 0;

  irq_ctrl_if bus ();

  irq_ctrl #(
    .N_IRQ(4),
    .VEC_BASE(32'h0000_0180),
    .VEC_SHIFT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irq(irq),
    .iack(iack),
    .bus(bus),
    .int_req(int_req),
    .int_vec(int_vec),
    .int_id(int_id),
    .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: mode 0 = waiting, 1 = requesting, 2 = servicing
  int   m_mode;
  int   m_id;
  bit [3:0] m_en;
  bit [3:0] m_pend;
  bit [3:0] m_last;

  function automatic int lowest(bit [3:0] c);
    for (int i = 0; i < 4; i++)
      if (c[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_id = 0;
      m_en = 0; m_pend = 0; m_last = 0;
    end else begin
      bit [3:0] events, avail, np;
      int nmode, nid;
      events = irq & ~m_last;
      avail  = m_pend & m_en;
      np = m_pend;
      nmode = m_mode;
      nid = m_id;
      if (bus.we && bus.addr == 2'd1) np = np & ~bus.wd[3:0];
      if (m_mode == 1 && iack) begin
        np[m_id] = 1'b0;
        nmode = 2;
      end
      np = np | events;
      if (m_mode == 0 && avail != 0) begin
        nmode = 1;
        nid = lowest(avail);
      end
      if (m_mode == 2 && bus.we && bus.addr == 2'd3) nmode = 0;
      if (bus.we && bus.addr == 2'd0) m_en = bus.wd[3:0];
      m_pend = np;
      m_mode = nmode;
      m_id = nid;
      m_last = irq;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e_rd;
    check("m_req", 32'(int_req), 32'(m_mode == 1));
    check("m_svc", 32'(in_service), 32'(m_mode == 2));
    check("m_id", 32'(int_id), 32'(m_id));
    check("m_vec", int_vec, 32'h180 + 32'(m_id) * 16);
    case (bus.addr)
      2'd0: e_rd = 32'(m_en);
      2'd1: e_rd = 32'(m_pend);
      2'd2: e_rd = 32'(m_id) + (m_mode == 1 ? 8 : 0)
                 + (m_mode == 2 ? 16 : 0);
      default: e_rd = 0;
    endcase
    check("m_rd", bus.rd, e_rd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wd = d;
    tick();
    bus.we = 1'b0; bus.wd = 0;
  endtask

  task automatic rdchk(string name, logic [1:0] a, logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.rd, exp);
  endtask

  task automatic do_iack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq = 0; iack = 0;
    bus.we = 0; bus.addr = 0; bus.wd = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_req", 32'(int_req), 0);
    check("rst_vec", int_vec, 32'h180);
    check("rst_id", 32'(int_id), 0);
    rdchk("rst_en", 2'd0, 0);
    rdchk("rst_pend", 2'd1, 0);
    rdchk("rst_stat", 2'd2, 0);

    // basic flow on source 0
    wr(2'd0, 32'h1);
    irq = 4'b0001;
    tick();
    rdchk("t1_pend", 2'd1, 32'h1);
    check("t1_req0", 32'(int_req), 0);
    tick();
    check("t1_req1", 32'(int_req), 1);
    check("t1_vec", int_vec, 32'h180);
    check("t1_id", 32'(int_id), 0);
    irq = 0;
    do_iack();
    check("t1_ackreq", 32'(int_req), 0);
    check("t1_svc", 32'(in_service), 1);
    rdchk("t1_pclr", 2'd1, 0);
    wr(2'd3, 32'h0);
    rdchk("t1_stat", 2'd2, 0);

    // priority between simultaneous edges
    wr(2'd0, 32'hF);
    irq = 4'b1010;
    tick();
    tick();
    check("t2_id1", 32'(int_id), 1);
    check("t2_vec1", int_vec, 32'h190);
    irq = 0;
    do_iack();
    wr(2'd3, 32'h0);
    check("t2_idle", 32'(int_req), 0);
    tick();
    check("t2_req3", 32'(int_req), 1);
    check("t2_id3", 32'(int_id), 3);
    check("t2_vec3", int_vec, 32'h1B0);
    do_iack();
    wr(2'd3, 32'h0);

    // masked source becomes live on enable write
    wr(2'd0, 32'h0);
    irq = 4'b0100;
    tick();
    irq = 0;
    tick();
    rdchk("t3_pend", 2'd1, 32'h4);
    check("t3_masked", 32'(int_req), 0);
    wr(2'd0, 32'h4);
    check("t3_wait", 32'(int_req), 0);
    tick();
    check("t3_req", 32'(int_req), 1);
    check("t3_id", 32'(int_id), 2);
    do_iack();
    wr(2'd3, 32'h0);

    // committed request survives mask and clear
    wr(2'd0, 32'h1);
    irq = 4'b0001;
    tick();
    irq = 0;
    tick();
    check("t4_req", 32'(int_req), 1);
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h1);
    tick();
    check("t4_hold", 32'(int_req), 1);
    check("t4_id", 32'(int_id), 0);
    rdchk("t4_stat", 2'd2, 32'h8);
    do_iack();
    check("t4_svc", 32'(in_service), 1);
    wr(2'd3, 32'h0);

    // held-high line, and set-beats-clear
    irq = 4'b0001;
    tick();
    rdchk("t5_set", 2'd1, 32'h1);
    wr(2'd1, 32'h1);
    tick(); tick();
    rdchk("t5_noretrig", 2'd1, 0);
    irq = 0;
    tick();
    irq = 4'b0001;
    wr(2'd1, 32'h1);
    rdchk("t5_setwins", 2'd1, 32'h1);

    // async reset while servicing
    wr(2'd0, 32'h1);
    tick();
    check("t6_req", 32'(int_req), 1);
    do_iack();
    check("t6_svc", 32'(in_service), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_svc", 32'(in_service), 0);
    check("t6_rst_req", 32'(int_req), 0);
    irq = 0;
    tick();
    rst_n = 1'b1;
    tick();
    rdchk("t6_en", 2'd0, 0);
    rdchk("t6_pend", 2'd1, 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
